// File: rtl/alu_seq_if.sv
// Handshake bus between operand-fetch, the sequential ALU and writeback.
// Upstream valid/ready, downstream valid/ready, plus result and status flags.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             div0;
  logic             busy;

  modport master (
    output in_valid, opcode, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, div0, busy
  );

  modport slave (
    input  in_valid, opcode, a_in, b_in, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, div0, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus radix-2 iterative
// multiply and restoring unsigned divide/remainder, with registered result and flags.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   io_bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {M_MUL, M_DIVU, M_REMU} mop_t;

  state_t           r_state;
  mop_t             r_mop;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_result;
  logic             r_z, r_n, r_c, r_v, r_div0;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_multi;
  mop_t             w_mop;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_mres;

  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && io_bus.out_ready);
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_shamt    = io_bus.b_in[SHW-1:0];
  assign w_add      = {1'b0, io_bus.a_in} + {1'b0, io_bus.b_in};
  assign w_sub      = {1'b0, io_bus.a_in} + {1'b0, ~io_bus.b_in} + (WIDTH+1)'(1);

  // Opcode decode and single-cycle datapath
  always_comb begin
    w_is_multi = 1'b0;
    w_mop      = M_MUL;
    w_res      = w_add[WIDTH-1:0];
    w_c        = 1'b0;
    w_v        = 1'b0;
    case (io_bus.opcode)
      5'b00010, 5'b00011: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (io_bus.a_in[WIDTH-1] ^ io_bus.b_in[WIDTH-1]) &
                (w_sub[WIDTH-1] ^ io_bus.a_in[WIDTH-1]);
      end
      5'b00100: w_res = io_bus.a_in >> w_shamt;
      5'b00101: w_res = WIDTH'($signed(io_bus.a_in) >>> w_shamt);
      5'b00110: w_res = io_bus.a_in << w_shamt;
      5'b00111: w_res = io_bus.a_in & io_bus.b_in;
      5'b01000: w_res = io_bus.a_in | io_bus.b_in;
      5'b01001: w_res = ~io_bus.a_in;
      5'b01100: w_res = io_bus.b_in;
      5'b01010: begin w_is_multi = 1'b1; w_mop = M_MUL;  end
      5'b01011: begin w_is_multi = 1'b1; w_mop = M_DIVU; end
      5'b01101: begin w_is_multi = 1'b1; w_mop = M_REMU; end
      default: begin
        w_c = w_add[WIDTH];
        w_v = ~(io_bus.a_in[WIDTH-1] ^ io_bus.b_in[WIDTH-1]) &
              (w_add[WIDTH-1] ^ io_bus.a_in[WIDTH-1]);
      end
    endcase
  end

  // One iteration step: shift-add multiply or restoring division.
  // A zero divisor always yields a non-negative trial, giving all-ones / A.
  assign w_rem_sh = {r_acc, r_q[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_x};

  always_comb begin
    w_acc_nxt = r_acc;
    w_x_nxt   = r_x;
    w_q_nxt   = r_q;
    if (r_mop == M_MUL) begin
      w_acc_nxt = r_q[0] ? (r_acc + r_x) : r_acc;
      w_x_nxt   = r_x << 1;
      w_q_nxt   = r_q >> 1;
    end else if (!w_trial[WIDTH]) begin
      w_acc_nxt = w_trial[WIDTH-1:0];
      w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_nxt = w_rem_sh[WIDTH-1:0];
      w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign w_mres = (r_mop == M_DIVU) ? w_q_nxt : w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mop       <= M_MUL;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_q         <= '0;
      r_result    <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_div0      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_x   <= w_x_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= S_DONE;
            r_result    <= w_mres;
            r_z         <= (w_mres == '0);
            r_n         <= w_mres[WIDTH-1];
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_div0      <= (r_mop != M_MUL) && (r_x == '0);
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          if ((r_state == S_DONE) && io_bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
          // Accept may coincide with the result handshake for back-to-back issue
          if (w_accept) begin
            if (w_is_multi) begin
              r_state     <= S_BUSY;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
              r_mop       <= w_mop;
              r_cnt       <= CW'(WIDTH);
              r_acc       <= '0;
              r_x         <= (w_mop == M_MUL) ? io_bus.a_in : io_bus.b_in;
              r_q         <= (w_mop == M_MUL) ? io_bus.b_in : io_bus.a_in;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_z         <= (w_res == '0);
              r_n         <= w_res[WIDTH-1];
              r_c         <= w_c;
              r_v         <= w_v;
              r_div0      <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.result    = r_result;
  assign io_bus.flag_z    = r_z;
  assign io_bus.flag_n    = r_n;
  assign io_bus.flag_c    = r_c;
  assign io_bus.flag_v    = r_v;
  assign io_bus.div0      = r_div0;
  assign io_bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=32 and WIDTH=8 instances, directed vectors with
// literal expectations plus a scoreboard fed by an arithmetic reference model.
module tb_alu_seq;
  typedef struct {
    logic [31:0] r;
    logic        z, n, c, v, d0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q32[$];
  exp_t q8[$];

  alu_seq_if #(.WIDTH(32)) b32 ();
  alu_seq_if #(.WIDTH(8))  b8 ();

  alu_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .io_bus(b32));
  alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .io_bus(b8));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
  endtask

  // Reference model straight from the opcode table, any width up to 32
  function automatic exp_t model(input int unsigned w, input logic [4:0] op,
                                 input longint unsigned ai, input longint unsigned bi);
    exp_t e;
    longint unsigned mask, a, b, r, sa_u, sr, sb;
    longint sa;
    int unsigned amt;
    mask = (longint'(1) << w) - 1;
    a = ai & mask;
    b = bi & mask;
    amt = int'(b % longint'(w));
    sa_u = (a >> (w - 1)) & 1;
    sb = (b >> (w - 1)) & 1;
    e.c = 1'b0; e.v = 1'b0; e.d0 = 1'b0;
    case (op)
      5'b00010, 5'b00011: begin
        r = (a - b) & mask;
        sr = (r >> (w - 1)) & 1;
        e.c = (a >= b);
        e.v = (sa_u != sb) && (sr != sa_u);
      end
      5'b00100: r = a >> amt;
      5'b00101: begin
        sa = (sa_u != 0) ? (longint'(a) - (longint'(1) << w)) : longint'(a);
        r = longint'(sa >>> amt) & mask;
      end
      5'b00110: r = (a << amt) & mask;
      5'b00111: r = a & b;
      5'b01000: r = a | b;
      5'b01001: r = ~a & mask;
      5'b01100: r = b;
      5'b01010: r = (a * b) & mask;
      5'b01011: begin r = (b == 0) ? mask : a / b; e.d0 = (b == 0); end
      5'b01101: begin r = (b == 0) ? a : a % b;    e.d0 = (b == 0); end
      default: begin
        r = (a + b) & mask;
        sr = (r >> (w - 1)) & 1;
        e.c = ((a + b) >> w) != 0;
        e.v = (sa_u == sb) && (sr != sa_u);
      end
    endcase
    e.r = 32'(r);
    e.z = (r == 0);
    e.n = ((r >> (w - 1)) & 1) != 0;
    return e;
  endfunction

  function automatic logic get_ready(input bit s8);
    return s8 ? b8.in_ready : b32.in_ready;
  endfunction

  function automatic logic get_valid(input bit s8);
    return s8 ? b8.out_valid : b32.out_valid;
  endfunction

  function automatic logic [31:0] get_result(input bit s8);
    return s8 ? {24'h0, b8.result} : b32.result;
  endfunction

  task automatic set_in(input bit s8, input logic v, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    if (s8) begin
      b8.in_valid = v; b8.opcode = op; b8.a_in = a[7:0]; b8.b_in = b[7:0];
    end else begin
      b32.in_valid = v; b32.opcode = op; b32.a_in = a; b32.b_in = b;
    end
  endtask

  task automatic push_exp(input bit s8, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    if (s8) q8.push_back(model(8, op, longint'(a), longint'(b)));
    else    q32.push_back(model(32, op, longint'(a), longint'(b)));
  endtask

  // Present an op at the negedge, wait for acceptance, return just after the accept edge
  task automatic drive(input bit s8, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int waits);
    waits = 0;
    @(negedge clk);
    set_in(s8, 1'b1, op, a, b);
    #1;
    while (!get_ready(s8) && waits < 200) begin
      @(negedge clk); #1; waits++;
    end
    if (!get_ready(s8)) note_fail("accept_wait");
    push_exp(s8, op, a, b);
    @(posedge clk); #1;
    set_in(s8, 1'b0, op, a, b);
  endtask

  // Issue, then measure cycles to out_valid and watch in_ready while busy
  task automatic run_op(input bit s8, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input string tag);
    int waits, lat, rdy_bad;
    drive(s8, op, a, b, waits);
    lat = 1;
    rdy_bad = 0;
    while (!get_valid(s8) && lat < 200) begin
      if (get_ready(s8)) rdy_bad++;
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_rdy_busy"}, 64'(rdy_bad), 64'd0);
  endtask

  // Scoreboard: every cycle a result is presented it must match the oldest expectation
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (b32.out_valid) begin
        if (q32.size() == 0) note_fail("sb32_empty");
        else begin
          check("sb32_res", 64'(b32.result), 64'(q32[0].r));
          check("sb32_flags", 64'({b32.flag_z, b32.flag_n, b32.flag_c, b32.flag_v, b32.div0}),
                64'({q32[0].z, q32[0].n, q32[0].c, q32[0].v, q32[0].d0}));
          if (b32.out_ready) void'(q32.pop_front());
        end
      end
      if (b8.out_valid) begin
        if (q8.size() == 0) note_fail("sb8_empty");
        else begin
          check("sb8_res", 64'(b8.result), 64'(q8[0].r[7:0]));
          check("sb8_flags", 64'({b8.flag_z, b8.flag_n, b8.flag_c, b8.flag_v, b8.div0}),
                64'({q8[0].z, q8[0].n, q8[0].c, q8[0].v, q8[0].d0}));
          if (b8.out_ready) void'(q8.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waits;
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_in(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    b32.out_ready = 1'b1;
    b8.out_ready  = 1'b1;

    #1 rst_n = 1'b0;
    #3;
    check("rst_out_valid", 64'(b32.out_valid), 64'd0);
    check("rst_result", 64'(b32.result), 64'd0);
    check("rst_flags", 64'({b32.flag_z, b32.flag_n, b32.flag_c, b32.flag_v, b32.div0, b32.busy}), 64'd0);
    check("rst8_out_valid", 64'(b8.out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(b32.in_ready), 64'd1);

    // Reset during the fifth BUSY cycle of a multiply
    drive(1'b0, 5'b01010, 32'd5, 32'd7, waits);
    check("mul_busy", 64'(b32.busy), 64'd1);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(b32.out_valid), 64'd0);
    check("midrst_busy", 64'(b32.busy), 64'd0);
    q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 64'(b32.in_ready), 64'd1);
    run_op(1'b0, 5'b00000, 32'd2, 32'd3, 1, "add_after_rst");
    check("add_after_rst_res", 64'(get_result(1'b0)), 64'd5);

    // Back-to-back single-cycle stream
    drive(1'b0, 5'b00000, 32'h7FFF_FFFF, 32'd1, waits);
    check("add_ovf_res", 64'(b32.result), 64'h8000_0000);
    check("add_ovf_vn", 64'({b32.flag_v, b32.flag_n, b32.out_valid}), 64'b111);
    drive(1'b0, 5'b00010, 32'd5, 32'd5, waits);
    check("sub_wait", 64'(waits), 64'd0);
    check("sub_zc", 64'({b32.result == 32'd0, b32.flag_z, b32.flag_c, b32.out_valid}), 64'b1111);
    drive(1'b0, 5'b00101, 32'h8000_0000, 32'd33, waits);
    check("asr_wait", 64'(waits), 64'd0);
    check("asr_res", 64'(b32.result), 64'hC000_0000);
    check("asr_valid", 64'(b32.out_valid), 64'd1);
    drive(1'b0, 5'b00100, 32'hF000_0000, 32'd68, waits);
    drive(1'b0, 5'b01001, 32'h0000_FFFF, 32'd0, waits);
    drive(1'b0, 5'b01100, 32'd0, 32'h1234_5678, waits);
    drive(1'b0, 5'b00011, 32'd3, 32'd7, waits);

    // Iterative ops
    run_op(1'b0, 5'b01010, 32'hFFFF_FFFF, 32'd3, 33, "mul32");
    check("mul32_res", 64'(b32.result), 64'hFFFF_FFFD);
    run_op(1'b0, 5'b01011, 32'd100, 32'd7, 33, "divu");
    check("divu_res", 64'(b32.result), 64'd14);
    run_op(1'b0, 5'b01101, 32'd100, 32'd7, 33, "remu");
    check("remu_res", 64'(b32.result), 64'd2);
    run_op(1'b0, 5'b01011, 32'd9, 32'd0, 33, "divu0");
    check("divu0_res", 64'({b32.result, 31'd0, b32.div0}), {32'hFFFF_FFFF, 32'd1});
    run_op(1'b0, 5'b01101, 32'd9, 32'd0, 33, "remu0");
    check("remu0_res", 64'({b32.result, 31'd0, b32.div0}), {32'd9, 32'd1});
    run_op(1'b0, 5'b00111, 32'hFF00_00FF, 32'h0F0F_0F0F, 1, "and_div0clr");
    check("and_div0clr_d0", 64'(b32.div0), 64'd0);

    // Backpressure on an AND, released together with a new OR
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    drive(1'b0, 5'b00111, 32'hF0F0_1234, 32'h0FF0_FFFF, waits);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("bp_res", 64'(b32.result), 64'h00F0_1234);
      check("bp_state", 64'({b32.out_valid, b32.in_ready, b32.flag_z, b32.flag_n}), 64'b1000);
    end
    @(negedge clk);
    b32.out_ready = 1'b1;
    set_in(1'b0, 1'b1, 5'b01000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    #1;
    check("bp_release_ready", 64'(b32.in_ready), 64'd1);
    push_exp(1'b0, 5'b01000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    check("or_res", 64'({b32.out_valid, b32.result}), {31'd0, 1'b1, 32'hFFF0_FFFF});

    // Narrow instance
    run_op(1'b1, 5'b00110, 32'h01, 32'h09, 1, "sl8");
    check("sl8_res", 64'(get_result(1'b1)), 64'h02);
    run_op(1'b1, 5'b01010, 32'h10, 32'h10, 9, "mul8");
    check("mul8_res", 64'({b8.result, b8.flag_z}), {55'd0, 8'h00, 1'b1});
    run_op(1'b1, 5'b11111, 32'h7F, 32'h01, 1, "op1f");
    check("op1f_res", 64'({b8.result, b8.flag_v, b8.flag_n}), {54'd0, 8'h80, 2'b11});
    run_op(1'b1, 5'b01101, 32'd200, 32'd7, 9, "remu8");
    check("remu8_res", 64'(get_result(1'b1)), 64'd4);
    run_op(1'b1, 5'b01011, 32'd200, 32'd0, 9, "divu8_0");
    check("divu8_0_res", 64'(get_result(1'b1)), 64'hFF);
    run_op(1'b1, 5'b00100, 32'h80, 32'h0F, 1, "lsr8");
    check("lsr8_res", 64'(get_result(1'b1)), 64'h01);
    run_op(1'b1, 5'b00010, 32'h80, 32'h01, 1, "sub8");

    repeat (3) @(negedge clk);
    #3;
    check("sb32_drained", 64'(q32.size()), 64'd0);
    check("sb8_drained", 64'(q8.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
